// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, bus-width constants and FSM encoding for the MEM-stage access unit.
package mem_access_unit_pkg;

    localparam int unsigned RegBusW     = 32;  // RegisterBus
    localparam int unsigned RegAddrBusW = 5;   // RegisterAddressBus
    localparam int unsigned AluOpBusW   = 8;
    localparam int unsigned MemStallBit = 4;

    localparam logic [AluOpBusW-1:0] OpLb  = 8'b1110_0000;
    localparam logic [AluOpBusW-1:0] OpLbu = 8'b1110_0100;
    localparam logic [AluOpBusW-1:0] OpLh  = 8'b1110_0001;
    localparam logic [AluOpBusW-1:0] OpLhu = 8'b1110_0101;
    localparam logic [AluOpBusW-1:0] OpLw  = 8'b1110_0011;
    localparam logic [AluOpBusW-1:0] OpSb  = 8'b1110_1000;
    localparam logic [AluOpBusW-1:0] OpSh  = 8'b1110_1001;
    localparam logic [AluOpBusW-1:0] OpSw  = 8'b1110_1011;

    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic WriteDisable = 1'b0;
    localparam logic WriteEnable  = 1'b1;

    localparam logic [RegBusW-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StBusy      = 2'd1,
        StWaitStall = 2'd2
    } mem_state_e;

    // Access width in bytes; 0 for anything that is not a load or store.
    function automatic logic [2:0] access_bytes(input logic [AluOpBusW-1:0] op);
        logic [2:0] n;
        n = 3'd0;
        case (op)
            OpLb, OpLbu, OpSb: n = 3'd1;
            OpLh, OpLhu, OpSh: n = 3'd2;
            OpLw, OpSw:        n = 3'd4;
            default:           n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian byte-lane logic: select generation, store replication,
// load extract/extend and alignment check.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [AluOpBusW-1:0] aluop,
    input  logic [1:0]           addr_lo,
    input  logic [RegBusW-1:0]   reg2,
    input  logic [RegBusW-1:0]   rdata,
    output logic                 is_mem,
    output logic                 is_load,
    output logic [3:0]           sel,
    output logic [RegBusW-1:0]   wdata,
    output logic [RegBusW-1:0]   load_data,
    output logic                 misalign
);

    logic [2:0]  nbytes;
    logic [3:0]  byte_sel;
    logic [7:0]  byte_val;
    logic [3:0]  half_sel;
    logic [15:0] half_val;

    always_comb begin
        byte_sel = 4'b0000;
        byte_val = 8'h00;
        unique case (addr_lo)
            2'b00: begin byte_sel = 4'b1000; byte_val = rdata[31:24]; end
            2'b01: begin byte_sel = 4'b0100; byte_val = rdata[23:16]; end
            2'b10: begin byte_sel = 4'b0010; byte_val = rdata[15:8];  end
            2'b11: begin byte_sel = 4'b0001; byte_val = rdata[7:0];   end
            default: ;
        endcase
        half_sel = addr_lo[1] ? 4'b0011 : 4'b1100;
        half_val = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        nbytes    = access_bytes(aluop);
        is_mem    = (nbytes != 3'd0);
        is_load   = 1'b0;
        sel       = 4'b0000;
        wdata     = ZeroWord;
        load_data = ZeroWord;
        misalign  = ((nbytes == 3'd2) && addr_lo[0]) || ((nbytes == 3'd4) && (addr_lo != 2'b00));

        case (aluop)
            OpLb: begin
                is_load   = 1'b1;
                sel       = byte_sel;
                load_data = {{24{byte_val[7]}}, byte_val};
            end
            OpLbu: begin
                is_load   = 1'b1;
                sel       = byte_sel;
                load_data = {24'h0, byte_val};
            end
            OpLh: begin
                is_load   = 1'b1;
                sel       = half_sel;
                load_data = {{16{half_val[15]}}, half_val};
            end
            OpLhu: begin
                is_load   = 1'b1;
                sel       = half_sel;
                load_data = {16'h0, half_val};
            end
            OpLw: begin
                is_load   = 1'b1;
                sel       = 4'b1111;
                load_data = rdata;
            end
            OpSb: begin
                sel   = byte_sel;
                wdata = {4{reg2[7:0]}};
            end
            OpSh: begin
                sel   = half_sel;
                wdata = {2{reg2[15:0]}};
            end
            OpSw: begin
                sel   = 4'b1111;
                wdata = reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: passes ALU/HI-LO results to mem_wb and runs loads/stores over a req/ack bus.
// Optional bus watchdog and bus_err port enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RegAddrBusW-1:0] ex_wd,
    input  logic                   ex_wreg,
    input  logic [RegBusW-1:0]     ex_wdata,
    input  logic [RegBusW-1:0]     ex_hi,
    input  logic [RegBusW-1:0]     ex_lo,
    input  logic                   ex_whilo,
    input  logic [AluOpBusW-1:0]   ex_aluop,
    input  logic [RegBusW-1:0]     ex_mem_addr,
    input  logic [RegBusW-1:0]     ex_reg2,
    input  logic [5:0]             stall,
    output logic [RegAddrBusW-1:0] mem_wd,
    output logic                   mem_wreg,
    output logic [RegBusW-1:0]     mem_wdata,
    output logic [RegBusW-1:0]     mem_hi,
    output logic [RegBusW-1:0]     mem_lo,
    output logic                   mem_whilo,
    output logic                   stallreq,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [3:0]             bus_sel,
    output logic [RegBusW-1:0]     bus_wdata,
    input  logic [RegBusW-1:0]     bus_rdata,
    input  logic                   bus_ack,
`ifdef MEM_BUS_TIMEOUT_EN
    output logic                   bus_err,
`endif
    output logic                   misalign
);

    mem_state_e         state_q, state_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [3:0]         bus_sel_q, bus_sel_d;
    logic [RegBusW-1:0] bus_wdata_q, bus_wdata_d;
    logic [RegBusW-1:0] rd_buf_q, rd_buf_d;
    logic               misalign_q, misalign_d;

    logic               la_is_mem, la_is_load, la_misalign;
    logic [3:0]         la_sel;
    logic [RegBusW-1:0] la_wdata, la_load_data, rdata_src;
    logic               mem_ok;
    logic               tmo_hit;
    logic               abort_q;

    // In WAIT_STALL the bus data is gone; extract from the captured word instead.
    assign rdata_src = (state_q == StWaitStall) ? rd_buf_q : bus_rdata;

    mem_lane_align u_lane_align (
        .aluop     (ex_aluop),
        .addr_lo   (ex_mem_addr[1:0]),
        .reg2      (ex_reg2),
        .rdata     (rdata_src),
        .is_mem    (la_is_mem),
        .is_load   (la_is_load),
        .sel       (la_sel),
        .wdata     (la_wdata),
        .load_data (la_load_data),
        .misalign  (la_misalign)
    );

    assign mem_ok = la_is_mem & ~la_misalign;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            abort_d;
    logic            bus_err_q;

    assign tmo_hit = (state_q == StBusy) && !bus_ack
                     && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        abort_d   = abort_q;
        unique case (state_q)
            StIdle: begin
                tmo_cnt_d = '0;
                abort_d   = 1'b0;
            end
            StBusy: begin
                if (!bus_ack) begin
                    tmo_cnt_d = tmo_cnt_q + CntW'(1);
                end
                abort_d = tmo_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            abort_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            abort_q   <= abort_d;
            bus_err_q <= tmo_hit;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign tmo_hit = 1'b0;
    assign abort_q = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        rd_buf_d    = rd_buf_q;
        // Only fire once the misaligned op actually leaves MEM, so a held op pulses once.
        misalign_d  = la_is_mem && la_misalign && (state_q == StIdle)
                      && (stall[MemStallBit] == NoStop);

        unique case (state_q)
            StIdle: begin
                if (mem_ok) begin
                    state_d     = StBusy;
                    bus_req_d   = 1'b1;
                    bus_we_d    = ~la_is_load;
                    bus_addr_d  = {ex_mem_addr[ADDR_W-1:2], 2'b00};
                    bus_sel_d   = la_sel;
                    bus_wdata_d = la_wdata;
                end
            end
            StBusy: begin
                if (bus_ack || tmo_hit) begin
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_sel_d   = 4'b0000;
                    bus_wdata_d = ZeroWord;
                    rd_buf_d    = bus_ack ? bus_rdata : ZeroWord;
                    state_d     = (stall[MemStallBit] == Stop) ? StWaitStall : StIdle;
                end
            end
            StWaitStall: begin
                if (stall[MemStallBit] == NoStop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= ZeroWord;
            rd_buf_q    <= ZeroWord;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            rd_buf_q    <= rd_buf_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign misalign  = misalign_q;

    always_comb begin
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        mem_whilo = ex_whilo;
        stallreq  = 1'b0;

        if (la_is_mem) begin
            if (la_misalign) begin
                mem_wreg  = WriteDisable;
                mem_wdata = ZeroWord;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        stallreq = 1'b1;
                        if (la_is_load) mem_wdata = ZeroWord;
                    end
                    StBusy: begin
                        if (bus_ack) begin
                            if (la_is_load) mem_wdata = la_load_data;
                        end else if (tmo_hit) begin
                            mem_wreg = WriteDisable;
                            if (la_is_load) mem_wdata = ZeroWord;
                        end else begin
                            stallreq = 1'b1;
                            if (la_is_load) mem_wdata = ZeroWord;
                        end
                    end
                    StWaitStall: begin
                        if (abort_q) begin
                            mem_wreg = WriteDisable;
                            if (la_is_load) mem_wdata = ZeroWord;
                        end else if (la_is_load) begin
                            mem_wdata = la_load_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
